inst_fetch_buf: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program-counter register. Each cycle the PC stage reports an enabled PC, this block issues a read to the synchronous instruction ROM and captures the returned word together with its PC. It queues each pair in a small FIFO and presents it to the decode stage over a valid/ready handshake. It back-pressures the PC stage through a stall output and supports a flush for taken branches/jumps.

---
 rtl/ifb_pkg.sv | 24 ++
 rtl/ifb_fifo.sv | 79 +++++++
 rtl/inst_fetch_buf.sv | 120 ++++++++++++
 tb/tb_inst_fetch_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifb_pkg
// Description : Shared widths, constants and the fetch-entry type used by
//               the instruction-fetch buffer and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package ifb_pkg;

  localparam int IFB_PC_W   = 6;
  localparam int IFB_INST_W = 32;
  localparam int IFB_DEPTH  = 2;

  // Canonical no-op instruction (addi x0, x0, 0)
  localparam logic [31:0] IFB_NOP = 32'h0000_0013;

  // One queued fetch: the PC and the word the ROM returned for it
  typedef struct packed {
    logic [IFB_PC_W-1:0]   pc;
    logic [IFB_INST_W-1:0] inst;
  } ifb_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifb_fifo
// Description : DEPTH-entry synchronous FIFO with push/pop/clear, occupancy
//               count and head-of-queue output. DEPTH must be a power of two
//               so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int W     = IFB_PC_W + IFB_INST_W,
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic [W-1:0]             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Next-state for pointers and count; clear beats any push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count, so no reset
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_buf
// Description : Instruction-fetch stage. Issues ROM reads for the PC stage,
//               tracks the single in-flight read, queues {pc, inst} pairs in
//               a small FIFO and hands them to decode over valid/ready.
//               Credit-based stall keeps queued + in-flight <= DEPTH.
//               Optional macro IFB_BYPASS_EN: an arriving response is shown
//               to decode directly when the FIFO is empty (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_buf
  import ifb_pkg::*;
#(
  parameter int PC_W   = IFB_PC_W,
  parameter int INST_W = IFB_INST_W,
  parameter int DEPTH  = IFB_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              ce_i,
  output logic              fetch_stall_o,
  input  logic              flush_i,
  output logic              rom_ce_o,
  output logic [PC_W-1:0]   rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [INST_W-1:0] id_inst_o,
  output logic [PC_W-1:0]   id_pc_o
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam int            EW      = PC_W + INST_W;
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);

  logic              req_v_q,  req_v_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;

  logic [CW-1:0]     w_count;
  logic              w_fifo_empty;
  logic [EW-1:0]     w_fifo_head;
  logic              w_push;
  logic              w_pop;
  logic              w_byp;
  logic [CW:0]       w_credits_used;

  // Credits come from registered state only, so decode's ready never
  // reaches the PC stage combinationally
  always_comb begin
    w_credits_used = {1'b0, w_count} + {{CW{1'b0}}, req_v_q};
    fetch_stall_o  = (w_credits_used >= C_DEPTH);
  end

  // ROM issue: blocked by stall, flush and reset; address parked at zero
  always_comb begin
    rom_ce_o   = ce_i & ~fetch_stall_o & ~flush_i & ~rst_i;
    rom_addr_o = rom_ce_o ? pc_i : '0;
    req_v_d    = rom_ce_o;
    req_pc_d   = pc_i;
  end

  // In-flight tracker for the read issued last cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
    end else begin
      req_v_q  <= req_v_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef IFB_BYPASS_EN
  // Response goes straight to decode when nothing is queued ahead of it
  assign w_byp = w_fifo_empty & req_v_q & ~flush_i & ~rst_i;
`else
  assign w_byp = 1'b0;
`endif

  // FIFO control: a response consumed through the bypass is not written;
  // a flush drops the arriving response and clears the queue
  always_comb begin
    w_pop  = ~w_fifo_empty & id_ready_i;
    w_push = req_v_q & ~flush_i & ~(w_byp & id_ready_i);
  end

  ifb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({req_pc_q, rom_data_i}),
    .count_o (w_count),
    .empty_o (w_fifo_empty),
    .head_o  (w_fifo_head)
  );

  // Decode-side outputs: FIFO head, else bypassed response, else zero
  always_comb begin
    id_valid_o = 1'b0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (!w_fifo_empty) begin
      id_valid_o           = 1'b1;
      {id_pc_o, id_inst_o} = w_fifo_head;
    end else if (w_byp) begin
      id_valid_o = 1'b1;
      id_pc_o    = req_pc_q;
      id_inst_o  = rom_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_buf
// Description : Self-checking bench for inst_fetch_buf. A transaction-level
//               model (queue of fetch entries plus one in-flight slot) and a
//               behavioural ROM / PC stage surround the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_buf;
  import ifb_pkg::*;

  localparam int PC_W   = IFB_PC_W;
  localparam int INST_W = IFB_INST_W;
  localparam int DEPTH  = IFB_DEPTH;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [PC_W-1:0]   pc_i;
  logic              ce_i;
  logic              fetch_stall_o;
  logic              flush_i;
  logic              rom_ce_o;
  logic [PC_W-1:0]   rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [INST_W-1:0] id_inst_o;
  logic [PC_W-1:0]   id_pc_o;

  int checks   = 0;
  int failures = 0;

  // Reference state
  ifb_entry_t      mq[$];
  bit              inflight;
  logic [PC_W-1:0] inflight_pc;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] flush_tgt;

  always #5 clk = ~clk;

  inst_fetch_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .ce_i          (ce_i),
    .fetch_stall_o (fetch_stall_o),
    .flush_i       (flush_i),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_inst_o     (id_inst_o),
    .id_pc_o       (id_pc_o)
  );

  function automatic logic [INST_W-1:0] rom_word(input logic [PC_W-1:0] a);
    return 32'h0000_0100 + {26'b0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set (except pc_i, driven from the
  // PC-stage model). Checks at negedge+1, model advances at posedge.
  task automatic cycle(input bit do_check);
    bit              stall_e, ce_e, byp_e, valid_e;
    logic [PC_W-1:0] addr_e;
    ifb_entry_t      head_e;
    logic            s_ce;
    logic [PC_W-1:0] s_addr;

    pc_i = pc_q;
    #1;
    stall_e = (mq.size() + int'(inflight)) >= DEPTH;
    ce_e    = ce_i && !stall_e && !flush_i && !rst_i;
    addr_e  = ce_e ? pc_i : '0;
    byp_e   = 1'b0;
`ifdef IFB_BYPASS_EN
    byp_e   = (mq.size() == 0) && inflight && !flush_i && !rst_i;
`endif
    valid_e = (mq.size() != 0) || byp_e;
    head_e  = '0;
    if (mq.size() != 0)  head_e = mq[0];
    else if (byp_e)      head_e = '{pc: inflight_pc, inst: rom_word(inflight_pc)};

    if (do_check) begin
      chk("fetch_stall", 64'(fetch_stall_o), 64'(stall_e));
      chk("rom_ce",      64'(rom_ce_o),      64'(ce_e));
      chk("rom_addr",    64'(rom_addr_o),    64'(addr_e));
      chk("id_valid",    64'(id_valid_o),    64'(valid_e));
      chk("id_pc",       64'(id_pc_o),       64'(head_e.pc));
      chk("id_inst",     64'(id_inst_o),     64'(head_e.inst));
    end

    s_ce   = rom_ce_o;
    s_addr = rom_addr_o;
    @(posedge clk);

    if (rst_i || flush_i) begin
      mq.delete();
      inflight = 1'b0;
    end else begin
      if (valid_e && id_ready_i && mq.size() != 0) mq.delete(0);
      if (inflight && !(byp_e && id_ready_i))
        mq.push_back('{pc: inflight_pc, inst: rom_word(inflight_pc)});
      inflight    = ce_e;
      inflight_pc = pc_i;
    end

    if (rst_i)        pc_q = '0;
    else if (flush_i) pc_q = flush_tgt;
    else if (s_ce)    pc_q = pc_q + 1'b1;

    #1;
    rom_data_i = (s_ce === 1'b1) ? rom_word(s_addr) : INST_W'($urandom());
    @(negedge clk);
  endtask

  initial begin
    rst_i      = 1'b1;
    ce_i       = 1'b0;
    flush_i    = 1'b0;
    id_ready_i = 1'b0;
    rom_data_i = '0;
    pc_q       = '0;
    flush_tgt  = '0;
    inflight   = 1'b0;
    inflight_pc = '0;
    @(negedge clk);

    // Reset: first edge initialises the design, then reset state is checked
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    rst_i = 1'b0;

    // Streaming with decode always ready
    ce_i       = 1'b1;
    id_ready_i = 1'b1;
    repeat (12) cycle(1'b1);

    // Decode back-pressure from a fresh start, then release
    rst_i = 1'b1;
    cycle(1'b1);
    rst_i      = 1'b0;
    id_ready_i = 1'b0;
    repeat (5) cycle(1'b1);
    id_ready_i = 1'b1;
    repeat (4) cycle(1'b1);

    // Full FIFO, single accepting cycle coinciding with a flush
    id_ready_i = 1'b0;
    repeat (4) cycle(1'b1);
    id_ready_i = 1'b1;
    flush_i    = 1'b1;
    flush_tgt  = 6'd10;
    cycle(1'b1);
    flush_i    = 1'b0;
    id_ready_i = 1'b0;
    repeat (3) cycle(1'b1);

    // Flush with one queued and one in flight
    id_ready_i = 1'b1;
    cycle(1'b1);
    id_ready_i = 1'b0;
    cycle(1'b1);
    flush_i   = 1'b1;
    flush_tgt = 6'd60;
    cycle(1'b1);
    flush_i = 1'b0;

    // PC wrap 63 -> 0 and FIFO pointer wrap over more than 10 entries
    id_ready_i = 1'b1;
    repeat (14) cycle(1'b1);

    // Reset in the middle of a stalled, full queue
    id_ready_i = 1'b0;
    repeat (4) cycle(1'b1);
    rst_i = 1'b1;
    cycle(1'b1);
    rst_i      = 1'b0;
    id_ready_i = 1'b1;
    repeat (6) cycle(1'b1);

    // Randomized traffic
    repeat (400) begin
      ce_i       = ($urandom_range(0, 7) != 0);
      id_ready_i = ($urandom_range(0, 2) != 0);
      flush_i    = ($urandom_range(0, 19) == 0);
      flush_tgt  = PC_W'($urandom());
      rst_i      = ($urandom_range(0, 59) == 0);
      cycle(1'b1);
    end

    // Drain
    rst_i      = 1'b0;
    flush_i    = 1'b0;
    ce_i       = 1'b0;
    id_ready_i = 1'b1;
    repeat (4) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
